dense_layer: RTL and testbench
==============================

DENSE_LAYER -- requirements
Module: dense_layer

Interface
REQ-001 Parameter W_FILE, default "../data/weights/dense_w.txt", binary text image of the weight ROM loaded at elaboration.
REQ-002 Parameter B_FILE, default "../data/weights/dense_b.txt", binary text image of the bias ROM; used only with DENSE_BIAS_EN.
REQ-003 clk  input  1  single clock; all state rising-edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 run  input  1  level start request.
REQ-006 d  input  N*HID_DIM*N_LEN  input matrix; element (r,k) at d[(r*HID_DIM+k)*N_LEN +: N_LEN], r<N, k<HID_DIM.
REQ-007 valid  output  1  result ready.
REQ-008 q  output  N*CHAR_NUM*N_LEN  result matrix; element (r,c) at q[(r*CHAR_NUM+c)*N_LEN +: N_LEN], c<CHAR_NUM.

Function
REQ-009 The block SHALL compute q(r,c) = sum over k of d(r,k)*W(k,c), plus B(c) when DENSE_BIAS_EN is defined.
REQ-010 All elements SHALL be two's-complement signed, N_LEN=16 bits, F_LEN=8 fractional bits.
REQ-011 Products SHALL be 2*N_LEN bits; the HID_DIM-term sum SHALL use a 2*N_LEN+5 bit accumulator with no intermediate overflow.
REQ-012 Bias SHALL be added after sign extension and left shift by F_LEN.
REQ-013 Final value SHALL be arithmetic-shifted right by F_LEN (truncation toward minus infinity), then saturated to [-32768, 32767].
REQ-014 W SHALL be a HID_DIM*CHAR_NUM ROM indexed k*CHAR_NUM+c; B SHALL be a CHAR_NUM ROM.
REQ-015 FSM states: IDLE, CALC, DONE.
REQ-016 IDLE->CALC when run=1 is sampled; d SHALL be latched internally on that edge.
REQ-017 CALC SHALL produce exactly one output element per cycle, order r-major then c, using HID_DIM parallel multipliers; row counter 0..N-1, column counter 0..CHAR_NUM-1.
REQ-018 Latency: valid SHALL rise N*CHAR_NUM+1 cycles (2001 for N=10, CHAR_NUM=200) after the edge that sampled run; CALC->DONE after the last element.
REQ-019 In DONE, valid=1 and q held while run=1; no restart while run stays high.
REQ-020 DONE->IDLE when run=0 is sampled; valid SHALL drop on that edge, q SHALL retain its last value.
REQ-021 run deasserted during CALC SHALL NOT abort the computation.
REQ-022 Changes on d after the start edge SHALL NOT affect the result.

Reset
REQ-023 rst_n=0 SHALL force IDLE, valid=0, q=0, counters=0 immediately, including mid-CALC.
REQ-024 After rst_n rises, a new run SHALL start a fresh computation from element (0,0).

Configuration
REQ-025 Macro DENSE_BIAS_EN defined: B ROM instantiated and bias added per REQ-012; undefined: no B ROM, bias term is zero, B_FILE ignored.

Structure
REQ-026 Shared package/header consts SHALL hold N=10, HID_DIM=24, CHAR_NUM=200, N_LEN=16, F_LEN=8.
REQ-027 One sub-module dense_mac SHALL compute the HID_DIM-term dot product, shift and saturation combinationally from one row of d and one column of W.

Verification
REQ-028 Reset then run=1 with d all zero, bias off -> valid high at cycle 2001, q all zero.
REQ-029 d(r,k)=0x0100 (1.0) for all r,k, W(k,c)=0x0100 -> every q(r,c)=0x1800 (24.0).
REQ-030 d(r,k)=0x7FFF, W all 0x7FFF -> every q saturates to 0x7FFF; W all 0x8000 -> 0x8000.
REQ-031 rst_n pulsed low at cycle 1000 of CALC -> valid=0, q=0 at once; new run -> correct result after 2001 cycles.
REQ-032 run held high after valid -> valid stays 1, no recompute; run=0 -> valid 0 next edge, q unchanged; run=1 again -> recompute.
REQ-033 Random d against golden file dense_layer_out_tb with DENSE_BIAS_EN defined -> q matches bit-exactly after 5500 cycles.

Source files
------------

// File: rtl/dense_layer_pkg.sv
// Shared dimensions, fixed-point widths, FSM encoding and the output saturation helper
// for the dense layer.
package dense_layer_pkg;

    localparam int N        = 10;
    localparam int HID_DIM  = 24;
    localparam int CHAR_NUM = 200;
    localparam int N_LEN    = 16;
    localparam int F_LEN    = 8;

    localparam int P_LEN    = 2 * N_LEN;
    localparam int ACC_LEN  = 2 * N_LEN + 5;
    localparam int ROW_W    = $clog2(N);
    localparam int COL_W    = $clog2(CHAR_NUM);
    localparam int ELEM_W   = $clog2(N * CHAR_NUM);
    localparam int W_DEPTH  = HID_DIM * CHAR_NUM;
    localparam int W_IDX_W  = $clog2(W_DEPTH);

    localparam logic signed [ACC_LEN-1:0] SAT_MAX = ACC_LEN'(32767);
    localparam logic signed [ACC_LEN-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    // Arithmetic shift drops the fraction (floor), then clamp into the N_LEN-bit range.
    function automatic logic [N_LEN-1:0] shift_sat(input logic signed [ACC_LEN-1:0] acc);
        logic signed [ACC_LEN-1:0] sh;
        sh = acc >>> F_LEN;
        if (sh > SAT_MAX) begin
            shift_sat = {1'b0, {(N_LEN-1){1'b1}}};
        end else if (sh < SAT_MIN) begin
            shift_sat = {1'b1, {(N_LEN-1){1'b0}}};
        end else begin
            shift_sat = sh[N_LEN-1:0];
        end
    endfunction

endpackage

// File: rtl/dense_mac.sv
// Combinational HID_DIM-term signed dot product of one d row and one W column, with bias,
// fixed-point rescale and saturation.
module dense_mac
    import dense_layer_pkg::*;
(
    input  logic [HID_DIM*N_LEN-1:0] row_i,
    input  logic [HID_DIM*N_LEN-1:0] col_i,
    input  logic [N_LEN-1:0]         bias_i,
    output logic [N_LEN-1:0]         res_o
);

    logic signed [P_LEN-1:0]   prod [HID_DIM];
    logic signed [ACC_LEN-1:0] psum [HID_DIM+1];

    // Bias lives in the same Q-format as the products, hence the F_LEN pre-shift.
    assign psum[0] = ACC_LEN'($signed(bias_i)) <<< F_LEN;

    for (genvar k = 0; k < HID_DIM; k++) begin : g_mac
        assign prod[k]   = P_LEN'($signed(row_i[k*N_LEN +: N_LEN]))
                         * P_LEN'($signed(col_i[k*N_LEN +: N_LEN]));
        assign psum[k+1] = psum[k] + ACC_LEN'(prod[k]);
    end

    assign res_o = shift_sat(psum[HID_DIM]);

endmodule

// File: rtl/dense_layer.sv
// Dense layer q = d * W (+ B): one output element per cycle, r-major then c.
// Bias ROM and bias term are present only when DENSE_BIAS_EN is defined.
module dense_layer
    import dense_layer_pkg::*;
#(
    parameter string W_FILE = "../data/weights/dense_w.txt",
    parameter string B_FILE = "../data/weights/dense_b.txt"
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        run,
    input  logic [N*HID_DIM*N_LEN-1:0]  d,
    output logic                        valid,
    output logic [N*CHAR_NUM*N_LEN-1:0] q
);

    localparam int D_BITS     = N * HID_DIM * N_LEN;
    localparam int Q_BITS     = N * CHAR_NUM * N_LEN;
    localparam int D_BASE_W   = $clog2(D_BITS);
    localparam int Q_BASE_W   = $clog2(Q_BITS);

    state_e             state_q, state_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic               last_q, last_d;
    logic               valid_q, valid_d;
    logic [D_BITS-1:0]  d_lat_q, d_lat_d;
    logic [Q_BITS-1:0]  q_q, q_d;

    logic [ELEM_W-1:0]        elem_idx;
    logic [D_BASE_W-1:0]      d_base;
    logic [Q_BASE_W-1:0]      q_base;
    logic [HID_DIM*N_LEN-1:0] d_row;
    logic [HID_DIM*N_LEN-1:0] w_col;
    logic [N_LEN-1:0]         bias;
    logic [N_LEN-1:0]         mac_res;

    logic [N_LEN-1:0] w_rom [W_DEPTH];
    logic unused_w_file;
    assign unused_w_file = (W_FILE != "");

`ifdef DENSE_BIAS_EN
    logic [N_LEN-1:0] b_rom [CHAR_NUM];
    logic unused_b_file;
    assign unused_b_file = (B_FILE != "");
    assign bias          = b_rom[col_q];
`else
    logic unused_b_file;
    assign unused_b_file = (B_FILE != "");
    assign bias          = '0;
`endif

    for (genvar k = 0; k < HID_DIM; k++) begin : g_wcol
        logic [W_IDX_W-1:0] w_idx;
        assign w_idx = W_IDX_W'(k * CHAR_NUM) + W_IDX_W'(col_q);
        assign w_col[k*N_LEN +: N_LEN] = w_rom[w_idx];
    end

    assign d_base   = D_BASE_W'(row_q) * D_BASE_W'(HID_DIM * N_LEN);
    assign d_row    = d_lat_q[d_base +: HID_DIM*N_LEN];
    assign elem_idx = ELEM_W'(row_q) * ELEM_W'(CHAR_NUM) + ELEM_W'(col_q);
    assign q_base   = Q_BASE_W'(elem_idx) * Q_BASE_W'(N_LEN);

    dense_mac u_mac (
        .row_i  (d_row),
        .col_i  (w_col),
        .bias_i (bias),
        .res_o  (mac_res)
    );

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        last_d  = last_q;
        d_lat_d = d_lat_q;
        q_d     = q_q;
        case (state_q)
            StIdle: begin
                if (run) begin
                    state_d = StCalc;
                    d_lat_d = d;
                    row_d   = '0;
                    col_d   = '0;
                    last_d  = 1'b0;
                end
            end
            StCalc: begin
                // One extra CALC cycle after the last element lines valid up with N*CHAR_NUM+1.
                if (last_q) begin
                    state_d = StDone;
                end else begin
                    q_d[q_base +: N_LEN] = mac_res;
                    if (col_q == COL_W'(CHAR_NUM - 1)) begin
                        col_d = '0;
                        if (row_q == ROW_W'(N - 1)) begin
                            row_d  = '0;
                            last_d = 1'b1;
                        end else begin
                            row_d = row_q + ROW_W'(1);
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            StDone: begin
                if (!run) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        valid_d = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            row_q   <= '0;
            col_q   <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            d_lat_q <= '0;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            d_lat_q <= d_lat_d;
            q_q     <= q_d;
        end
    end

    assign valid = valid_q;
    assign q     = q_q;

endmodule

// File: tb/tb_dense_layer.sv
// Directed bench for dense_layer: weights are poked into the ROM, expected matrices come
// from a behavioural model and are queued at start, then popped when valid rises.
module tb_dense_layer;
    import dense_layer_pkg::*;

    localparam int DW      = N * HID_DIM * N_LEN;
    localparam int QW      = N * CHAR_NUM * N_LEN;
    localparam int LAT     = N * CHAR_NUM + 1;
    localparam int MAXWAIT = LAT + 100;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          run;
    logic [DW-1:0] d;
    logic          valid;
    logic [QW-1:0] q;

    logic signed [N_LEN-1:0] w_tb [W_DEPTH];
    logic signed [N_LEN-1:0] b_tb [CHAR_NUM];
    logic [QW-1:0]           exp_q [$];
    logic [QW-1:0]           last_exp;
    logic [DW-1:0]           d_keep;
    int                      n_assert = 0;
    int                      n_fail   = 0;

    dense_layer #(
        .W_FILE (""),
        .B_FILE ("")
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (run),
        .d     (d),
        .valid (valid),
        .q     (q)
    );

    always #5 clk = ~clk;

    function automatic logic [QW-1:0] model(input logic [DW-1:0] din);
        logic [QW-1:0]           res;
        longint                  acc;
        logic signed [N_LEN-1:0] a;
        res = '0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < CHAR_NUM; c++) begin
                acc = 0;
                for (int k = 0; k < HID_DIM; k++) begin
                    a   = din[(r*HID_DIM+k)*N_LEN +: N_LEN];
                    acc = acc + longint'(a) * longint'(w_tb[k*CHAR_NUM+c]);
                end
`ifdef DENSE_BIAS_EN
                acc = acc + longint'(b_tb[c]) * 256;
`endif
                acc = acc >>> 8;
                if (acc > 32767)       res[(r*CHAR_NUM+c)*N_LEN +: N_LEN] = 16'h7fff;
                else if (acc < -32768) res[(r*CHAR_NUM+c)*N_LEN +: N_LEN] = 16'h8000;
                else                   res[(r*CHAR_NUM+c)*N_LEN +: N_LEN] = acc[15:0];
            end
        end
        return res;
    endfunction

    function automatic logic [DW-1:0] d_const(input logic [N_LEN-1:0] v);
        return {(N*HID_DIM){v}};
    endfunction

    function automatic logic [DW-1:0] d_rand();
        logic [DW-1:0] r;
        for (int i = 0; i < N * HID_DIM; i++) r[i*N_LEN +: N_LEN] = 16'($urandom_range(0, 1023)) - 16'd512;
        return r;
    endfunction

    task automatic set_w_const(input logic [N_LEN-1:0] v);
        for (int i = 0; i < W_DEPTH; i++) w_tb[i] = v;
    endtask

    task automatic set_rand_rom();
        for (int i = 0; i < W_DEPTH; i++) w_tb[i] = 16'($urandom_range(0, 1023)) - 16'd512;
        for (int i = 0; i < CHAR_NUM; i++) b_tb[i] = 16'($urandom_range(0, 65535));
    endtask

    task automatic load_rom();
        for (int i = 0; i < W_DEPTH; i++) dut.w_rom[i] = w_tb[i];
`ifdef DENSE_BIAS_EN
        for (int i = 0; i < CHAR_NUM; i++) dut.b_rom[i] = b_tb[i];
`endif
    endtask

    task automatic check_bit(input string tag, input logic got, input logic exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_q(input string tag, input logic [QW-1:0] exp);
        int bad;
        bad = 0;
        n_assert++;
        assert (q === exp) else begin
            n_fail++;
            for (int i = N * CHAR_NUM - 1; i >= 0; i--)
                if (q[i*N_LEN +: N_LEN] !== exp[i*N_LEN +: N_LEN]) bad = i;
            $error("FAIL %s: element %0d got %h expected %h", tag, bad,
                   q[bad*N_LEN +: N_LEN], exp[bad*N_LEN +: N_LEN]);
        end
    endtask

    // Returns at the sampling edge of run.
    task automatic start(input logic [DW-1:0] din);
        @(negedge clk);
        d   = din;
        run = 1'b1;
        exp_q.push_back(model(din));
        @(posedge clk);
    endtask

    task automatic wait_result(input string tag);
        int cyc;
        cyc = 0;
        while (cyc < MAXWAIT) begin
            @(posedge clk);
            cyc++;
            #1;
            if (valid === 1'b1) break;
        end
        check_int({tag, " latency"}, cyc, LAT);
        if (exp_q.size() > 0) begin
            last_exp = exp_q.pop_front();
            check_q({tag, " q"}, last_exp);
        end else begin
            check_int({tag, " scoreboard"}, 0, 1);
        end
    endtask

    task automatic drop_run(input string tag);
        @(negedge clk);
        run = 1'b0;
        @(posedge clk);
        #1;
        check_bit({tag, " valid drop"}, valid, 1'b0);
        check_q({tag, " q retained"}, last_exp);
    endtask

    initial begin
        rst_n = 1'b0;
        run   = 1'b0;
        d     = '0;
        for (int i = 0; i < CHAR_NUM; i++) b_tb[i] = '0;
        set_w_const(16'h0100);
        load_rom();
        repeat (2) @(posedge clk);
        #1;
        check_bit("reset valid", valid, 1'b0);
        check_q("reset q", '0);
        @(negedge clk);
        rst_n = 1'b1;

        // All-zero input
        start(d_const(16'h0000));
        wait_result("zero");
        drop_run("zero");

        // 1.0 * 1.0 summed 24 times; d scrambled and run dropped mid-computation
        start(d_const(16'h0100));
        #2;
        d   = d_rand();
        run = 1'b0;
        wait_result("ones");
        @(posedge clk);
        #1;
        check_bit("ones valid after run low", valid, 1'b0);
        check_q("ones q retained", last_exp);

        // Positive saturation, then hold with run high
        set_w_const(16'h7fff);
        load_rom();
        d_keep = d_const(16'h7fff);
        start(d_keep);
        wait_result("sat max");
        d = d_rand();
        repeat (5) @(posedge clk);
        #1;
        check_bit("hold valid", valid, 1'b1);
        check_q("hold q", last_exp);
        drop_run("hold");

        // Negative saturation doubles as the restart after run toggled
        set_w_const(16'h8000);
        load_rom();
        start(d_keep);
        wait_result("sat min");
        drop_run("sat min");

        // Reset in the middle of a computation
        set_rand_rom();
        load_rom();
        start(d_rand());
        repeat (1000) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_bit("mid reset valid", valid, 1'b0);
        check_q("mid reset q", '0);
        last_exp = exp_q.pop_back();
        run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        start(d_rand());
        wait_result("after reset");
        drop_run("after reset");

        // Fresh random weights, bias and inputs
        set_rand_rom();
        load_rom();
        start(d_rand());
        wait_result("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
